// File: rtl/fp_add_arb_pkg.sv
// Shared types and constants for the arbitrated fixed-point adder.
package fp_add_arb_pkg;

  // Output register occupancy.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } res_state_e;

  localparam int                   OVF_CNT_W   = 8;
  localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/fp_add.sv
// Combinational signed fixed-point adder: aligns Q(N1.M1) and Q(N2.M2)
// operands onto a common Q(max N . max M) grid and adds with wraparound.
module fp_add
  import fp_add_arb_pkg::*;
#(
  parameter  int N1 = 4,
  parameter  int M1 = 12,
  parameter  int N2 = 6,
  parameter  int M2 = 10,
  localparam int MM = max_int(M1, M2),
  localparam int W  = max_int(N1, N2) + MM
) (
  input  logic [N1+M1-1:0] a,
  input  logic [N2+M2-1:0] b,
  output logic [W-1:0]     sum,
  output logic             ovf
);

  logic [W-1:0] a_al;
  logic [W-1:0] b_al;

  // Sign-extend first so the fraction shift never drops significant bits.
  assign a_al = W'($signed(a)) << (MM - M1);
  assign b_al = W'($signed(b)) << (MM - M2);
  assign sum  = a_al + b_al;
  assign ovf  = (a_al[W-1] == b_al[W-1]) && (sum[W-1] != a_al[W-1]);

endmodule

// File: rtl/fp_add_arb.sv
// Two-requester round-robin front end sharing one fp_add, with a single
// result register and a saturating overflow counter.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | result register empty, res_valid = 0
// ST_FULL  | result register holds a result, res_valid = 1
module fp_add_arb
  import fp_add_arb_pkg::*;
#(
  parameter  int N1 = 4,
  parameter  int M1 = 12,
  parameter  int N2 = 6,
  parameter  int M2 = 10,
  localparam int W  = max_int(N1, N2) + max_int(M1, M2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [N1+M1-1:0]     req0_a,
  input  logic [N2+M2-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [N1+M1-1:0]     req1_a,
  input  logic [N2+M2-1:0]     req1_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [W-1:0]         res_data,
  output logic                 res_ovf,
  output logic                 res_id,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam logic [0:0] S_EMPTY = ST_EMPTY;
  localparam logic [0:0] S_FULL  = ST_FULL;

  logic [0:0]       state;
  logic             last_id;
  logic             grant;
  logic             can_accept;
  logic             accept;
  logic [N1+M1-1:0] op_a;
  logic [N2+M2-1:0] op_b;
  logic [W-1:0]     sum;
  logic             ovf;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_id;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign can_accept = !rst && ((state == S_EMPTY) || res_ready);
  assign req0_ready = can_accept && !grant;
  assign req1_ready = can_accept && grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign op_a       = grant ? req1_a : req0_a;
  assign op_b       = grant ? req1_b : req0_b;
  assign res_valid  = (state == S_FULL);

  fp_add #(
    .N1(N1),
    .M1(M1),
    .N2(N2),
    .M2(M2)
  ) u_fp_add (
    .a  (op_a),
    .b  (op_b),
    .sum(sum),
    .ovf(ovf)
  );

  // Result register, occupancy FSM, round-robin pointer and overflow counter.
  // last_id resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_EMPTY;
      res_data  <= '0;
      res_ovf   <= 1'b0;
      res_id    <= 1'b0;
      last_id   <= 1'b1;
      ovf_count <= '0;
    end else if (accept) begin
      state    <= S_FULL;
      res_data <= sum;
      res_ovf  <= ovf;
      res_id   <= grant;
      last_id  <= grant;
      if (ovf && (ovf_count != OVF_CNT_MAX)) begin
        ovf_count <= ovf_count + OVF_CNT_W'(1);
      end
    end else if ((state == S_FULL) && res_ready) begin
      state <= S_EMPTY;
    end
  end

endmodule

// File: tb/tb_fp_add_arb.sv
// Randomized scoreboard bench for fp_add_arb with directed corner cases.
module tb_fp_add_arb;

  localparam int N1 = 4;
  localparam int M1 = 12;
  localparam int N2 = 6;
  localparam int M2 = 10;
  localparam int MM = (M1 > M2) ? M1 : M2;
  localparam int W  = ((N1 > N2) ? N1 : N2) + MM;
  localparam int WA = N1 + M1;
  localparam int WB = N2 + M2;

  typedef struct {
    logic [W-1:0] data;
    logic         ovf;
    logic         id;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [WA-1:0] req0_a, req1_a;
  logic [WB-1:0] req0_b, req1_b;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic          res_ovf;
  logic          res_id;
  logic [7:0]    ovf_count;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_last = 1;
  bit   m_full = 0;
  int   m_cnt = 0;

  fp_add_arb #(.N1(N1), .M1(M1), .N2(N2), .M2(M2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .res_id    (res_id),
    .ovf_count (ovf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: real-valued sum on the finer grid, wrapped to W bits.
  function automatic exp_t model(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic id);
    exp_t   r;
    longint av, bv, tot;
    longint lmax, lmin;
    av   = longint'($signed(a));
    bv   = longint'($signed(b));
    tot  = av * (longint'(1) << (MM - M1)) + bv * (longint'(1) << (MM - M2));
    lmax = (longint'(1) << (W - 1)) - 1;
    lmin = -(longint'(1) << (W - 1));
    r.ovf  = (tot > lmax) || (tot < lmin);
    r.data = tot[W-1:0];
    r.id   = id;
    return r;
  endfunction

  // Monitor: the register must always match the oldest unconsumed result.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got data %0h with no result pending", res_data);
      end else begin
        check("res_data", 64'(res_data), 64'(sb[0].data));
        check("res_ovf", 64'(res_ovf), 64'(sb[0].ovf));
        check("res_id", 64'(res_id), 64'(sb[0].id));
        if (res_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic cycle(input logic v0, input logic v1,
                       input logic [WA-1:0] a0, input logic [WB-1:0] b0,
                       input logic [WA-1:0] a1, input logic [WB-1:0] b1,
                       input logic rr, output int dacc);
    bit   can;
    int   g;
    exp_t e;
    @(posedge clk);
    #1;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    res_ready = rr;
    @(negedge clk);
    check("res_valid", 64'(res_valid), 64'(m_full));
    check("ovf_count", 64'(ovf_count), 64'(m_cnt));
    can = !m_full || rr;
    if (v0 && v1) g = (m_last == 0) ? 1 : 0;
    else g = v1 ? 1 : 0;
    check("req0_ready", 64'(req0_ready), 64'(can && g == 0));
    check("req1_ready", 64'(req1_ready), 64'(can && g == 1));
    dacc = (v0 && req0_ready) ? 0 : ((v1 && req1_ready) ? 1 : -1);
    if (can && ((g == 0 && v0) || (g == 1 && v1))) begin
      e = (g == 0) ? model(a0, b0, 1'b0) : model(a1, b1, 1'b1);
      if (e.ovf && m_cnt < 255) m_cnt++;
      sb.push_back(e);
      m_last = g;
      m_full = 1;
    end else if (m_full && rr) begin
      m_full = 0;
    end
  endtask

  task automatic rand_cycle(input logic v0, input logic v1, input logic rr, output int dacc);
    logic [31:0] r0, r1;
    r0 = $urandom();
    r1 = $urandom();
    cycle(v0, v1, r0[WA-1:0], r0[31:32-WB], r1[WA-1:0], r1[31:32-WB], rr, dacc);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    check("rst_req0_ready", 64'(req0_ready), 64'(0));
    check("rst_req1_ready", 64'(req1_ready), 64'(0));
    sb.delete();
    m_full = 0;
    m_cnt  = 0;
    m_last = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_data", 64'(res_data), 64'(0));
    check("rst_res_ovf", 64'(res_ovf), 64'(0));
    check("rst_res_id", 64'(res_id), 64'(0));
    check("rst_ovf_count", 64'(ovf_count), 64'(0));
  endtask

  initial begin
    int acc;
    int exp_ids[4];
    logic [31:0] r;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // 1.0 + 1.0 from requester 0.
    cycle(1'b1, 1'b0, 16'h1000, 16'h0400, 16'h0, 16'h0, 1'b1, acc);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, acc);
    check("one_plus_one_valid", 64'(res_valid), 64'(1));
    check("one_plus_one_data", 64'(res_data), 64'h02000);
    check("one_plus_one_ovf", 64'(res_ovf), 64'(0));
    check("one_plus_one_id", 64'(res_id), 64'(0));

    // Positive overflow case.
    cycle(1'b1, 1'b0, 16'h7FFF, 16'h7C00, 16'h0, 16'h0, 1'b1, acc);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, acc);
    check("ovf_case_data", 64'(res_data), 64'h26FFF);
    check("ovf_case_ovf", 64'(res_ovf), 64'(1));
    check("ovf_case_count", 64'(ovf_count), 64'(1));

    // Tie alternation from a fresh pointer.
    do_reset();
    exp_ids = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      rand_cycle(1'b1, 1'b1, 1'b1, acc);
      check("rr_grant", 64'(acc), 64'(exp_ids[i]));
    end
    rand_cycle(1'b0, 1'b0, 1'b1, acc);

    // Backpressure: hold three cycles, then drain and accept together.
    rand_cycle(1'b1, 1'b1, 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      rand_cycle(1'b1, 1'b1, 1'b0, acc);
      check("stall_no_accept", 64'(acc), 64'hFFFF_FFFF_FFFF_FFFF);
    end
    rand_cycle(1'b1, 1'b1, 1'b1, acc);
    check("release_accepts", 64'(acc >= 0), 64'(1));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      rand_cycle(r[0], r[1], (r[3:2] != 2'b00), acc);
    end

    // Saturation of the overflow counter.
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 1'b0, 16'h7FFF, 16'h7C00, 16'h0, 16'h0, 1'b1, acc);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 16'h0, 16'h0, 16'h7FFF, 16'h7C00, 1'b1, acc);
    end
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, acc);
    check("ovf_count_saturated", 64'(ovf_count), 64'(255));

    // Reset while holding a result under backpressure.
    rand_cycle(1'b0, 1'b1, 1'b0, acc);
    rand_cycle(1'b0, 1'b0, 1'b0, acc);
    check("pre_rst_full", 64'(res_valid), 64'(1));
    do_reset();
    rand_cycle(1'b1, 1'b1, 1'b1, acc);
    check("post_rst_tie", 64'(acc), 64'(0));

    repeat (3) rand_cycle(1'b0, 1'b0, 1'b1, acc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_add_arb.md
FP_ADD_ARB -- requirements
Module: fp_add_arb

Interface
REQ-001 Parameter N1, default 4, meaning signed integer bits of operand A.
REQ-002 Parameter M1, default 12, meaning fractional bits of operand A.
REQ-003 Parameter N2, default 6, meaning signed integer bits of operand B.
REQ-004 Parameter M2, default 10, meaning fractional bits of operand B.
REQ-005 Derived widths: W = max(N1,N2) + max(M1,M2), default 18; result format is Q(max(N1,N2).max(M1,M2)).
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 req0_valid / req1_valid  in  1  requester k has an operand pair.
REQ-009 req0_ready / req1_ready  out  1  requester k's pair is accepted this cycle.
REQ-010 req0_a / req1_a  in  N1+M1  operand A, signed Q(N1.M1).
REQ-011 req0_b / req1_b  in  N2+M2  operand B, signed Q(N2.M2).
REQ-012 res_valid  out  1  result register holds a result.
REQ-013 res_ready  in  1  consumer accepts the result.
REQ-014 res_data  out  W  signed sum, wrapping (no saturation).
REQ-015 res_ovf  out  1  two's-complement overflow of res_data.
REQ-016 res_id  out  1  index of the requester that produced res_data.
REQ-017 ovf_count  out  8  count of accepted operations that overflowed; saturates at 255.

Function
REQ-018 One shared fixed-point adder SHALL serve both requesters.
REQ-019 Adder arithmetic: sign-extend A and B to W bits, left-shift the operand with fewer fractional bits by |M1-M2|, add mod 2^W.
REQ-020 Overflow: both aligned operands have equal sign bits and the sum's sign bit differs from them.
REQ-021 Output FSM states: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-022 can_accept = EMPTY, or (FULL and res_ready).
REQ-023 Grant: if only one req_valid is high, grant that requester; if both are high, grant the requester not granted last (round-robin).
REQ-024 reqk_ready = can_accept and grant==k; at most one ready is high per cycle; ready does not depend on the other requester's data.
REQ-025 Acceptance (valid and ready) at cycle t: res_data, res_ovf and res_id are loaded at edge t+1, and the FSM enters or stays in FULL; latency is 1 cycle.
REQ-026 FULL with res_ready=1 and no acceptance -> EMPTY; FULL with res_ready=0 -> hold all res_* stable.
REQ-027 Simultaneous drain and accept in FULL: new result replaces old; full throughput of 1 op/cycle.
REQ-028 The round-robin pointer updates only on acceptance, never on an unaccepted grant.
REQ-029 ovf_count increments at the edge where an overflowing result is loaded; it holds at 255.

Reset
REQ-030 rst SHALL set FSM=EMPTY, res_valid=0, res_data=0, res_ovf=0, res_id=0, ovf_count=0, and the pointer so that req0 wins the first tie.
REQ-031 rst asserted mid-operation discards any held result; req_ready is 0 during the rst cycle.

Structure
REQ-032 A shared package holds the FSM state enum and the ovf_count width/max constants.
REQ-033 The adder datapath is one instance of the existing combinational fp_add module; arbitration, FSM and registers live in fp_add_arb.

Verification
REQ-034 Reset then req0 with A=16'h1000 (1.0) and B=16'h0400 (1.0) -> next cycle res_valid=1, res_data=18'h02000, res_ovf=0, res_id=0.
REQ-035 req0 with A=16'h7FFF and B=16'h7C00 -> res_data=18'h26FFF, res_ovf=1, ovf_count=1.
REQ-036 Both valid for 4 cycles with res_ready=1 -> grants alternate 0,1,0,1; res_id follows one cycle later.
REQ-037 Hold res_ready=0 for 3 cycles while FULL -> both ready=0 and res_* stable; on release, one drain+accept occurs in the same cycle.
REQ-038 Overflowing pairs streamed for 300 accepted ops -> ovf_count=255 and stays 255.
REQ-039 rst pulsed while FULL with res_ready=0 -> next cycle res_valid=0, ovf_count=0, and req0 wins the next tie.
